// File: rtl/data_xlate_ctrl_pkg.sv
// Shared definitions for the data-side translate/request stage:
// FSM states, memory exception codes, DMW field positions and an
// alignment helper.
package data_xlate_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_EXC    = 2'd3
   } state_e;

   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_TLBR = 6'h3f;
   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_PME  = 6'h04;

   // DMW CSR layout
   localparam int DMW_PLV0_BIT = 0;
   localparam int DMW_PLV3_BIT = 3;
   localparam int DMW_MAT_LO   = 4;
   localparam int DMW_VSEG_LO  = 29;

   // Size 3 is treated as a word access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] low);
      case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = low[0];
         default: misaligned = |low;
      endcase
   endfunction

endpackage

// File: rtl/data_xlate_ctrl_dmw_hit.sv
// Direct-mapped window match for one DMW CSR.
// Ports: vseg (vaddr[31:29]), plv (current privilege), dmw (CSR value)
//        -> hit (segment and privilege match), mat (window MAT field).
// Paging-mode qualification is applied by the caller.
module data_xlate_ctrl_dmw_hit
   import data_xlate_ctrl_pkg::*;
(
   input  logic [2:0]  vseg,
   input  logic [1:0]  plv,
   input  logic [31:0] dmw,
   output logic        hit,
   output logic [1:0]  mat
);

   logic unused_dmw_bits;
   assign unused_dmw_bits = ^{dmw[28:6], dmw[2:1]};

   assign hit = (vseg == dmw[DMW_VSEG_LO +: 3]) &&
                (((plv == 2'd0) && dmw[DMW_PLV0_BIT]) ||
                 ((plv == 2'd3) && dmw[DMW_PLV3_BIT]));
   assign mat = dmw[DMW_MAT_LO +: 2];

endmodule

// File: rtl/data_xlate_ctrl.sv
// Data-side request stage between EX and addr_trans/dcache.
// Accepts one load/store from EX, presents its address to addr_trans, checks
// the TLB result one cycle later, then either issues a tagged dcache request
// (valid/ready) or emits a one-cycle memory exception with the faulting vaddr.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   ex_req_*                         EX request (valid/ready, wr, size, vaddr, wdata)
//   flush                            kills any in-flight request
//   csr_da/pg/plv/datm/dmw0/dmw1     CSR state for mode and window selection
//   data_fetch, data_vaddr,
//   data_dmw0_en/dmw1_en,
//   data_addr_trans_en               to addr_trans
//   data_tlb_*, data_tag/index/offset  from addr_trans
//   dc_req_*                         dcache request channel
//   exc_valid/ecode/badv             exception pulse
module data_xlate_ctrl
   import data_xlate_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_req_valid,
   output logic        ex_req_ready,
   input  logic        ex_req_wr,
   input  logic [1:0]  ex_req_size,
   input  logic [31:0] ex_req_vaddr,
   input  logic [31:0] ex_req_wdata,
   input  logic        flush,
   input  logic        csr_da,
   input  logic        csr_pg,
   input  logic [1:0]  csr_plv,
   input  logic [1:0]  csr_datm,
   input  logic [31:0] csr_dmw0,
   input  logic [31:0] csr_dmw1,
   output logic        data_fetch,
   output logic [31:0] data_vaddr,
   output logic        data_dmw0_en,
   output logic        data_dmw1_en,
   output logic        data_addr_trans_en,
   input  logic        data_tlb_found,
   input  logic        data_tlb_v,
   input  logic        data_tlb_d,
   input  logic [1:0]  data_tlb_plv,
   input  logic [1:0]  data_tlb_mat,
   input  logic [19:0] data_tag,
   input  logic [7:0]  data_index,
   input  logic [3:0]  data_offset,
   output logic        dc_req_valid,
   input  logic        dc_req_ready,
   output logic        dc_req_wr,
   output logic [1:0]  dc_req_size,
   output logic [19:0] dc_req_tag,
   output logic [7:0]  dc_req_index,
   output logic [3:0]  dc_req_offset,
   output logic [31:0] dc_req_wdata,
   output logic        dc_req_uncached,
   output logic        exc_valid,
   output logic [5:0]  exc_ecode,
   output logic [31:0] exc_badv
);

   state_e      state_q, state_d;
   logic [31:0] vaddr_q, vaddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [19:0] tag_q, tag_d;
   logic [7:0]  index_q, index_d;
   logic [3:0]  offset_q, offset_d;
   logic        uncached_q, uncached_d;
   logic [5:0]  ecode_q, ecode_d;

   logic       accept, pg_mode, hit0, hit1, trans_en;
   logic [1:0] mat0, mat1;
   logic       fault, uncached_res;
   logic [5:0] fault_ecode;

   assign ex_req_ready = (state_q == ST_IDLE) && !flush;
   assign accept       = ex_req_valid && ex_req_ready;
   assign data_fetch   = accept;
   assign data_vaddr   = accept ? ex_req_vaddr : vaddr_q;

   data_xlate_ctrl_dmw_hit u_dmw0 (
      .vseg(data_vaddr[31:29]), .plv(csr_plv), .dmw(csr_dmw0), .hit(hit0), .mat(mat0));
   data_xlate_ctrl_dmw_hit u_dmw1 (
      .vseg(data_vaddr[31:29]), .plv(csr_plv), .dmw(csr_dmw1), .hit(hit1), .mat(mat1));

   // Windows only apply in paging mode; DMW0 has priority over DMW1.
   assign pg_mode            = !csr_da && csr_pg;
   assign data_dmw0_en       = pg_mode && hit0;
   assign data_dmw1_en       = pg_mode && hit1 && !hit0;
   assign trans_en           = pg_mode && !hit0 && !hit1;
   assign data_addr_trans_en = trans_en;

   // TLB fault priority: miss, invalid, privilege, then dirty on store.
   always_comb begin
      fault       = 1'b1;
      fault_ecode = ECODE_TLBR;
      if (!data_tlb_found)              fault_ecode = ECODE_TLBR;
      else if (!data_tlb_v)             fault_ecode = wr_q ? ECODE_PIS : ECODE_PIL;
      else if (csr_plv > data_tlb_plv)  fault_ecode = ECODE_PPI;
      else if (wr_q && !data_tlb_d)     fault_ecode = ECODE_PME;
      else                              fault = 1'b0;
   end

   always_comb begin
      if (trans_en)          uncached_res = (data_tlb_mat == 2'd0);
      else if (data_dmw0_en) uncached_res = (mat0 == 2'd0);
      else if (data_dmw1_en) uncached_res = (mat1 == 2'd0);
      else                   uncached_res = (csr_datm == 2'd0);
   end

   always_comb begin
      state_d    = state_q;
      vaddr_d    = vaddr_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      size_d     = size_q;
      tag_d      = tag_q;
      index_d    = index_q;
      offset_d   = offset_q;
      uncached_d = uncached_q;
      ecode_d    = ecode_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               vaddr_d = ex_req_vaddr;
               wdata_d = ex_req_wdata;
               wr_d    = ex_req_wr;
               size_d  = ex_req_size;
               if (misaligned(ex_req_size, ex_req_vaddr[1:0])) begin
                  ecode_d = ECODE_ALE;
                  state_d = ST_EXC;
               end else begin
                  state_d = ST_LOOKUP;
               end
            end
         end
         ST_LOOKUP: begin
            if (trans_en && fault) begin
               ecode_d = fault_ecode;
               state_d = ST_EXC;
            end else begin
               tag_d      = data_tag;
               index_d    = data_index;
               offset_d   = data_offset;
               uncached_d = uncached_res;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: if (dc_req_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // A flush coinciding with dc_req_ready still lets the cache keep the request.
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         vaddr_q    <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         size_q     <= '0;
         tag_q      <= '0;
         index_q    <= '0;
         offset_q   <= '0;
         uncached_q <= 1'b0;
         ecode_q    <= '0;
      end else begin
         state_q    <= state_d;
         vaddr_q    <= vaddr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         size_q     <= size_d;
         tag_q      <= tag_d;
         index_q    <= index_d;
         offset_q   <= offset_d;
         uncached_q <= uncached_d;
         ecode_q    <= ecode_d;
      end
   end

   assign dc_req_valid    = (state_q == ST_ISSUE);
   assign dc_req_wr       = wr_q;
   assign dc_req_size     = size_q;
   assign dc_req_tag      = tag_q;
   assign dc_req_index    = index_q;
   assign dc_req_offset   = offset_q;
   assign dc_req_wdata    = wdata_q;
   assign dc_req_uncached = uncached_q;

   assign exc_valid = (state_q == ST_EXC);
   assign exc_ecode = exc_valid ? ecode_q : 6'd0;
   assign exc_badv  = exc_valid ? vaddr_q : 32'd0;

endmodule

// File: tb/tb_data_xlate_ctrl.sv
// Self-checking bench for data_xlate_ctrl: directed scenarios plus randomized
// requests checked against a behavioural model of the translation rules.
module tb_data_xlate_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ex_req_valid, ex_req_ready, ex_req_wr;
   logic [1:0]  ex_req_size;
   logic [31:0] ex_req_vaddr, ex_req_wdata;
   logic        flush;
   logic        csr_da, csr_pg;
   logic [1:0]  csr_plv, csr_datm;
   logic [31:0] csr_dmw0, csr_dmw1;
   logic        data_fetch;
   logic [31:0] data_vaddr;
   logic        data_dmw0_en, data_dmw1_en, data_addr_trans_en;
   logic        data_tlb_found, data_tlb_v, data_tlb_d;
   logic [1:0]  data_tlb_plv, data_tlb_mat;
   logic [19:0] data_tag;
   logic [7:0]  data_index;
   logic [3:0]  data_offset;
   logic        dc_req_valid, dc_req_ready, dc_req_wr;
   logic [1:0]  dc_req_size;
   logic [19:0] dc_req_tag;
   logic [7:0]  dc_req_index;
   logic [3:0]  dc_req_offset;
   logic [31:0] dc_req_wdata;
   logic        dc_req_uncached;
   logic        exc_valid;
   logic [5:0]  exc_ecode;
   logic [31:0] exc_badv;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // addr_trans stand-in: index/offset follow data_vaddr combinationally
   assign data_index  = data_vaddr[11:4];
   assign data_offset = data_vaddr[3:0];

   data_xlate_ctrl dut (
      .clk(clk), .resetn(resetn),
      .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready), .ex_req_wr(ex_req_wr),
      .ex_req_size(ex_req_size), .ex_req_vaddr(ex_req_vaddr), .ex_req_wdata(ex_req_wdata),
      .flush(flush), .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv),
      .csr_datm(csr_datm), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
      .data_fetch(data_fetch), .data_vaddr(data_vaddr), .data_dmw0_en(data_dmw0_en),
      .data_dmw1_en(data_dmw1_en), .data_addr_trans_en(data_addr_trans_en),
      .data_tlb_found(data_tlb_found), .data_tlb_v(data_tlb_v), .data_tlb_d(data_tlb_d),
      .data_tlb_plv(data_tlb_plv), .data_tlb_mat(data_tlb_mat), .data_tag(data_tag),
      .data_index(data_index), .data_offset(data_offset),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_wr(dc_req_wr),
      .dc_req_size(dc_req_size), .dc_req_tag(dc_req_tag), .dc_req_index(dc_req_index),
      .dc_req_offset(dc_req_offset), .dc_req_wdata(dc_req_wdata),
      .dc_req_uncached(dc_req_uncached), .exc_valid(exc_valid), .exc_ecode(exc_ecode),
      .exc_badv(exc_badv)
   );

   typedef struct packed {
      bit       exc;
      bit [5:0] ecode;
      bit       unc;
      bit       d0;
      bit       d1;
      bit       tr;
   } exp_t;

   function automatic bit win_match(bit [31:0] va, bit [31:0] w, bit [1:0] plv);
      return ((va >> 29) == (w >> 29)) && ((plv == 0 && w[0]) || (plv == 3 && w[3]));
   endfunction

   // Outcome of one request under the current CSR / TLB inputs.
   function automatic exp_t model(bit wr, bit [1:0] size, bit [31:0] va);
      exp_t e;
      int   bytes;
      bit   paging, h0, h1;
      bit [1:0] mat;
      bytes  = (size == 0) ? 1 : (size == 1) ? 2 : 4;
      paging = csr_pg && !csr_da;
      h0 = paging && win_match(va, csr_dmw0, csr_plv);
      h1 = paging && win_match(va, csr_dmw1, csr_plv);
      e = '0;
      e.d0 = h0;
      e.d1 = h1 && !h0;
      e.tr = paging && !h0 && !h1;
      if (va % bytes != 0)                         begin e.exc = 1; e.ecode = 6'h09; end
      else if (e.tr && !data_tlb_found)            begin e.exc = 1; e.ecode = 6'h3f; end
      else if (e.tr && !data_tlb_v)                begin e.exc = 1; e.ecode = wr ? 6'h02 : 6'h01; end
      else if (e.tr && csr_plv > data_tlb_plv)     begin e.exc = 1; e.ecode = 6'h07; end
      else if (e.tr && wr && !data_tlb_d)          begin e.exc = 1; e.ecode = 6'h04; end
      mat = e.tr ? data_tlb_mat : h0 ? csr_dmw0[5:4] : h1 ? csr_dmw1[5:4] : csr_datm;
      e.unc = (mat == 0);
      return e;
   endfunction

   // Drives one request through to completion; dly = cycles dc_req_ready stays low.
   task automatic do_req(input bit wr, input bit [1:0] size, input bit [31:0] va,
                         input bit [31:0] wd, input int dly);
      exp_t     e;
      bit [19:0] tag;
      e   = model(wr, size, va);
      tag = e.tr ? 20'($urandom) : va[31:12];
      @(negedge clk);
      ex_req_valid = 1; ex_req_wr = wr; ex_req_size = size; ex_req_vaddr = va;
      ex_req_wdata = wd; data_tag = tag;
      #1;
      checks++;
      if ({ex_req_ready, data_fetch, data_vaddr} !== {1'b1, 1'b1, va}) begin
         errors++;
         $display("FAIL accept: ready/fetch/vaddr=%b/%b/%h want 1/1/%h", ex_req_ready, data_fetch, data_vaddr, va);
      end
      checks++;
      if ({data_dmw0_en, data_dmw1_en, data_addr_trans_en} !== {e.d0, e.d1, e.tr}) begin
         errors++;
         $display("FAIL mode_sel va=%h: dmw0/dmw1/trans=%b%b%b want %b%b%b", va,
                  data_dmw0_en, data_dmw1_en, data_addr_trans_en, e.d0, e.d1, e.tr);
      end
      @(negedge clk);
      ex_req_valid = 0; ex_req_vaddr = $urandom; ex_req_wdata = $urandom;
      #1;
      if (!(e.exc && e.ecode == 6'h09)) begin
         checks++;
         if ({exc_valid, dc_req_valid, ex_req_ready, data_vaddr} !== {1'b0, 1'b0, 1'b0, va}) begin
            errors++;
            $display("FAIL lookup va=%h: exc/dcv/ready/vaddr=%b/%b/%b/%h want 0/0/0/%h", va,
                     exc_valid, dc_req_valid, ex_req_ready, data_vaddr, va);
         end
         @(negedge clk); #1;
      end
      if (e.exc) begin
         checks++;
         if ({exc_valid, exc_ecode, exc_badv, dc_req_valid} !== {1'b1, e.ecode, va, 1'b0}) begin
            errors++;
            $display("FAIL exc va=%h: valid/ecode/badv/dcv=%b/%h/%h/%b want 1/%h/%h/0", va,
                     exc_valid, exc_ecode, exc_badv, dc_req_valid, e.ecode, va);
         end
         @(negedge clk); #1;
      end else begin
         for (int k = 0; k <= dly; k++) begin
            checks++;
            if ({dc_req_valid, dc_req_wr, dc_req_size, dc_req_tag, dc_req_index, dc_req_offset,
                 dc_req_wdata, dc_req_uncached, exc_valid} !==
                {1'b1, wr, size, tag, va[11:4], va[3:0], wd, e.unc, 1'b0}) begin
               errors++;
               $display("FAIL issue va=%h cyc%0d: v/wr/sz/tag/idx/off/wd/unc=%b/%b/%0d/%h/%h/%h/%h/%b want 1/%b/%0d/%h/%h/%h/%h/%b",
                        va, k, dc_req_valid, dc_req_wr, dc_req_size, dc_req_tag, dc_req_index,
                        dc_req_offset, dc_req_wdata, dc_req_uncached, wr, size, tag, va[11:4],
                        va[3:0], wd, e.unc);
            end
            if (k == dly) dc_req_ready = 1;
            @(negedge clk); #1;
         end
         dc_req_ready = 0;
      end
      checks++;
      if ({exc_valid, dc_req_valid, ex_req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL done va=%h: exc/dcv/ready=%b%b%b want 001", va, exc_valid, dc_req_valid, ex_req_ready);
      end
   endtask

   task automatic set_csr(bit da, bit pg, bit [1:0] plv, bit [1:0] datm, bit [31:0] w0, bit [31:0] w1);
      csr_da = da; csr_pg = pg; csr_plv = plv; csr_datm = datm; csr_dmw0 = w0; csr_dmw1 = w1;
   endtask

   task automatic set_tlb(bit f, bit v, bit d, bit [1:0] plv, bit [1:0] mat);
      data_tlb_found = f; data_tlb_v = v; data_tlb_d = d; data_tlb_plv = plv; data_tlb_mat = mat;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({ex_req_ready, dc_req_valid, exc_valid, dc_req_tag, dc_req_wdata, exc_ecode, exc_badv, data_fetch} !==
          {1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 6'd0, 32'd0, 1'b1}) begin
         // data_fetch follows ex_req_valid&&ready even in reset; capture is held off by the flops
         errors++;
         $display("FAIL reset: ready=%b dcv=%b exc=%b tag=%h wd=%h ecode=%h badv=%h", ex_req_ready,
                  dc_req_valid, exc_valid, dc_req_tag, dc_req_wdata, exc_ecode, exc_badv);
      end
      @(negedge clk);
      ex_req_valid = 0;
      resetn = 1;
      @(negedge clk); #1;
      checks++;
      if ({dc_req_valid, exc_valid, dc_req_wdata} !== {1'b0, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL reset_nocapture: dcv=%b exc=%b wd=%h want 0/0/0", dc_req_valid, exc_valid, dc_req_wdata);
      end
   endtask

   task automatic test_direct();
      set_csr(1, 0, 0, 1, 0, 0);
      do_req(0, 2, 32'h1c00_0100, 32'h0, 2);
      do_req(1, 0, 32'h0000_0013, 32'hdead_beef, 0);
      set_csr(1, 0, 0, 0, 0, 0);
      do_req(0, 3, 32'h1234_5678, 32'h0, 1);
   endtask

   task automatic test_dmw();
      set_csr(0, 1, 0, 1, 32'h8000_0011, 32'h0);
      do_req(1, 2, 32'h8000_0040, 32'h1111_2222, 0);
      // both windows hit: DMW0 must win (MAT 0 in DMW0 -> uncached)
      set_csr(0, 1, 3, 1, 32'hA000_0008, 32'hA000_0018);
      do_req(0, 1, 32'hA000_0102, 32'h0, 1);
   endtask

   task automatic test_tlb_faults();
      set_csr(0, 1, 0, 1, 32'h0, 32'h0);
      set_tlb(0, 1, 1, 0, 1);
      do_req(0, 2, 32'h0040_2000, 32'h0, 0);
      set_tlb(1, 1, 0, 0, 1);
      do_req(1, 2, 32'h0040_2004, 32'h5, 0);
      set_csr(0, 1, 3, 1, 32'h0, 32'h0);
      set_tlb(1, 1, 1, 0, 1);
      do_req(0, 2, 32'h0040_2008, 32'h0, 0);
      set_tlb(1, 0, 1, 3, 1);
      do_req(0, 0, 32'h0040_2009, 32'h0, 0);
      do_req(1, 0, 32'h0040_200a, 32'h0, 0);
      set_tlb(1, 1, 1, 3, 0);
      do_req(1, 1, 32'h0040_200e, 32'h77, 1);
   endtask

   task automatic test_ale();
      set_csr(1, 0, 0, 1, 0, 0);
      do_req(0, 1, 32'h0000_1001, 32'h0, 0);
      do_req(1, 2, 32'h0000_1002, 32'h0, 0);
   endtask

   task automatic test_flush();
      set_csr(1, 0, 0, 1, 0, 0);
      data_tag = 20'h1c000;
      // flush while ISSUE is stalled
      @(negedge clk);
      ex_req_valid = 1; ex_req_wr = 0; ex_req_size = 2; ex_req_vaddr = 32'h1c00_0200;
      @(negedge clk); ex_req_valid = 0;
      @(negedge clk);
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (dc_req_valid !== 1'b1) begin
         errors++; $display("FAIL stall_hold: dcv=%b want 1", dc_req_valid);
      end
      flush = 1; #1;
      checks++;
      if ({ex_req_ready, dc_req_valid} !== 2'b01) begin
         errors++; $display("FAIL flush_issue_cyc: ready/dcv=%b%b want 01", ex_req_ready, dc_req_valid);
      end
      @(negedge clk); flush = 0; #1;
      checks++;
      if ({dc_req_valid, exc_valid, ex_req_ready} !== 3'b001) begin
         errors++; $display("FAIL flush_issue: dcv/exc/ready=%b%b%b want 001", dc_req_valid, exc_valid, ex_req_ready);
      end
      // flush in IDLE blocks acceptance
      @(negedge clk); flush = 1; ex_req_valid = 1; #1;
      checks++;
      if ({ex_req_ready, data_fetch} !== 2'b00) begin
         errors++; $display("FAIL flush_idle: ready/fetch=%b%b want 00", ex_req_ready, data_fetch);
      end
      @(negedge clk); flush = 0; ex_req_valid = 0;
      @(negedge clk); #1;
      checks++;
      if ({dc_req_valid, exc_valid, ex_req_ready} !== 3'b001) begin
         errors++; $display("FAIL flush_idle_after: dcv/exc/ready=%b%b%b want 001", dc_req_valid, exc_valid, ex_req_ready);
      end
      // flush in LOOKUP of a faulting request suppresses the exception
      set_csr(0, 1, 0, 1, 0, 0);
      set_tlb(0, 0, 0, 0, 0);
      @(negedge clk); ex_req_valid = 1; ex_req_vaddr = 32'h0040_3000;
      @(negedge clk); ex_req_valid = 0; flush = 1;
      @(negedge clk); flush = 0; #1;
      checks++;
      if ({exc_valid, dc_req_valid, ex_req_ready} !== 3'b001) begin
         errors++; $display("FAIL flush_lookup: exc/dcv/ready=%b%b%b want 001", exc_valid, dc_req_valid, ex_req_ready);
      end
      @(negedge clk); #1;
      checks++;
      if (exc_valid !== 1'b0) begin
         errors++; $display("FAIL flush_lookup_late: exc=%b want 0", exc_valid);
      end
      // flush together with dc_req_ready still ends in IDLE
      set_csr(1, 0, 0, 1, 0, 0);
      @(negedge clk); ex_req_valid = 1; ex_req_vaddr = 32'h1c00_0300;
      @(negedge clk); ex_req_valid = 0;
      @(negedge clk); flush = 1; dc_req_ready = 1;
      @(negedge clk); flush = 0; dc_req_ready = 0; #1;
      checks++;
      if ({dc_req_valid, exc_valid, ex_req_ready} !== 3'b001) begin
         errors++; $display("FAIL flush_ready: dcv/exc/ready=%b%b%b want 001", dc_req_valid, exc_valid, ex_req_ready);
      end
   endtask

   task automatic test_reset_mid();
      set_csr(1, 0, 0, 1, 0, 0);
      data_tag = 20'h1c000;
      @(negedge clk); ex_req_valid = 1; ex_req_wdata = 32'hcafe_f00d; ex_req_vaddr = 32'h1c00_0400;
      @(negedge clk); ex_req_valid = 0;
      @(negedge clk); #1;
      resetn = 0; #1;
      checks++;
      if ({dc_req_valid, dc_req_tag, dc_req_wdata, ex_req_ready} !== {1'b0, 20'd0, 32'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid: dcv=%b tag=%h wd=%h ready=%b want 0/0/0/1", dc_req_valid, dc_req_tag, dc_req_wdata, ex_req_ready);
      end
      @(negedge clk); resetn = 1;
   endtask

   task automatic test_random();
      bit [31:0] va, w0, w1;
      bit [1:0]  sz;
      for (int i = 0; i < 60; i++) begin
         va = $urandom; w0 = $urandom; w1 = $urandom;
         if ($urandom % 2) w0[31:29] = va[31:29];
         if ($urandom % 2) w1[31:29] = va[31:29];
         sz = 2'($urandom);
         if ($urandom % 4 != 0) va[1:0] = 2'b00;
         set_csr(($urandom % 4) == 0, ($urandom % 4) != 0, 2'($urandom), 2'($urandom), w0, w1);
         set_tlb(($urandom % 5) != 0, ($urandom % 5) != 0, ($urandom % 3) != 0, 2'($urandom), 2'($urandom));
         do_req(1'($urandom), sz, va, $urandom, int'($urandom % 3));
      end
   endtask

   initial begin
      resetn = 0; flush = 0; dc_req_ready = 0;
      ex_req_valid = 1; ex_req_wr = 0; ex_req_size = 2; ex_req_vaddr = 32'h1c00_0000; ex_req_wdata = 32'h1234;
      data_tag = 0;
      set_csr(1, 0, 0, 1, 0, 0);
      set_tlb(1, 1, 1, 3, 1);
      test_reset();
      test_direct();
      test_dmw();
      test_tlb_faults();
      test_ale();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
